// File: rtl/tick_sched_pkg.sv
// Shared command codes and channel state encoding for the tick timer scheduler.
package tick_sched_pkg;

  localparam logic [1:0] CMD_STOP     = 2'b00;
  localparam logic [1:0] CMD_ONESHOT  = 2'b01;
  localparam logic [1:0] CMD_PERIODIC = 2'b10;
  localparam logic [1:0] CMD_CLEAR    = 2'b11;

  typedef enum logic [1:0] {
    CH_IDLE     = 2'd0,
    CH_ONESHOT  = 2'd1,
    CH_PERIODIC = 2'd2
  } chan_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: base_tick is high for one clock every DIV clocks.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clock,
  input  logic reset,
  output logic base_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign base_tick = (cnt == LAST);

endmodule

// File: rtl/tick_timer_scheduler.sv
// Multi-channel countdown timers on a shared base tick, with expirations
// reported one at a time through a round-robin arbitrated valid/ready port.
module tick_timer_scheduler
  import tick_sched_pkg::*;
#(
  parameter int FREQ     = 50_000_000,
  parameter int TICK_HZ  = 1_000,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [$clog2(CHANNELS)-1:0] cfg_chan,
  input  logic [1:0]                  cfg_cmd,
  input  logic [CNT_W-1:0]            cfg_load,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(CHANNELS)-1:0] evt_chan,
  output logic                        evt_overrun,
  output logic [CHANNELS-1:0]         active,
  output logic                        base_tick
);

  localparam int DIV  = FREQ / TICK_HZ;
  localparam int CH_W = $clog2(CHANNELS);
  localparam logic [CH_W:0] CH_N = (CH_W + 1)'(CHANNELS);

  if ((FREQ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("tick_timer_scheduler: FREQ must be a multiple of TICK_HZ with DIV >= 2");
  end
  if (CHANNELS < 2) begin : g_bad_chan
    $error("tick_timer_scheduler: CHANNELS must be at least 2");
  end

  function automatic logic [CH_W-1:0] next_chan(input logic [CH_W-1:0] c);
    if (c == CH_W'(CHANNELS - 1)) return '0;
    return c + CH_W'(1);
  endfunction

  logic                cfg_ready_q;
  logic                cfg_fire;
  logic                evt_valid_q;
  logic [CH_W-1:0]     evt_chan_q;
  logic                evt_fire;
  logic [CH_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]    load_eff;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] overrun;
  logic [CHANNELS-1:0] clr_vec;
  logic [CHANNELS-1:0] hs_mask;
  logic [CHANNELS-1:0] eligible;
  logic [CH_W-1:0]     search_start;
  logic                win_found;
  logic [CH_W-1:0]     win_chan;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clock     (clock),
    .reset     (reset),
    .base_tick (base_tick)
  );

  assign cfg_fire = cfg_valid & cfg_ready_q;
  assign evt_fire = evt_valid_q & evt_ready;
  assign load_eff = (cfg_load == '0) ? CNT_W'(1) : cfg_load;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic             pend_q, pend_d;
    logic             ovr_q, ovr_d;
    logic             cmd_hit, clr_hit, hs_hit, expire;

    assign cmd_hit = cfg_fire && (cfg_chan == CH_W'(g));
    assign clr_hit = cmd_hit && (cfg_cmd == CMD_CLEAR);
    assign hs_hit  = evt_fire && (evt_chan_q == CH_W'(g));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= CH_IDLE;
        count_q <= '0;
        load_q  <= '0;
        pend_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        load_q  <= load_d;
        pend_q  <= pend_d;
        ovr_q   <= ovr_d;
      end
    end

    // A command on this channel shadows any base tick in the same cycle.
    always_comb begin
      state_d = state_q;
      count_d = count_q;
      load_d  = load_q;
      pend_d  = pend_q;
      ovr_d   = ovr_q;
      expire  = 1'b0;
      if (cmd_hit) begin
        case (cfg_cmd)
          CMD_STOP: begin
            state_d = CH_IDLE;
            count_d = '0;
          end
          CMD_ONESHOT, CMD_PERIODIC: begin
            state_d = (cfg_cmd == CMD_ONESHOT) ? CH_ONESHOT : CH_PERIODIC;
            count_d = load_eff;
            load_d  = load_eff;
          end
          default: ;
        endcase
      end else if (base_tick && state_q != CH_IDLE) begin
        if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          expire = 1'b1;
          if (state_q == CH_PERIODIC) begin
            count_d = load_q;
          end else begin
            state_d = CH_IDLE;
            count_d = '0;
          end
        end
      end

      if (clr_hit) begin
        pend_d = 1'b0;
        ovr_d  = 1'b0;
      end else if (hs_hit) begin
        pend_d = expire;
        ovr_d  = 1'b0;
      end else if (expire) begin
        if (pend_q) ovr_d = 1'b1;
        else        pend_d = 1'b1;
      end
    end

    assign pending[g] = pend_q;
    assign overrun[g] = ovr_q;
    assign clr_vec[g] = clr_hit;
    assign active[g]  = (state_q != CH_IDLE);
  end

  // Channels being acknowledged or cleared this cycle must not win the next slot.
  always_comb begin
    hs_mask = '0;
    if (evt_fire) hs_mask[evt_chan_q] = 1'b1;
    eligible     = pending & ~hs_mask & ~clr_vec;
    search_start = evt_fire ? next_chan(evt_chan_q) : rr_ptr;
  end

  always_comb begin
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    win_found = 1'b0;
    win_chan  = '0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum = {1'b0, search_start} + (CH_W + 1)'(i);
      if (sum >= CH_N) sum = sum - CH_N;
      idx = sum[CH_W-1:0];
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_chan  = idx;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cfg_ready_q <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_chan_q  <= '0;
      rr_ptr      <= '0;
    end else begin
      cfg_ready_q <= 1'b1;
      if (evt_fire) rr_ptr <= next_chan(evt_chan_q);
      if (!evt_valid_q || evt_fire) begin
        evt_valid_q <= win_found;
        if (win_found) evt_chan_q <= win_chan;
      end else if (clr_vec[evt_chan_q]) begin
        evt_valid_q <= 1'b0;
      end
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign evt_valid   = evt_valid_q;
  assign evt_chan    = evt_chan_q;
  assign evt_overrun = evt_valid_q & overrun[evt_chan_q];

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Directed bench for tick_timer_scheduler with DIV=10, four channels, 8-bit counts.
module tb_tick_timer_scheduler;

  localparam logic [1:0] C_STOP = 2'b00;
  localparam logic [1:0] C_ONE  = 2'b01;
  localparam logic [1:0] C_PER  = 2'b10;
  localparam logic [1:0] C_CLR  = 2'b11;

  logic       clock;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_chan;
  logic [1:0] cfg_cmd;
  logic [7:0] cfg_load;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_chan;
  logic       evt_overrun;
  logic [3:0] active;
  logic       base_tick;

  int checks;
  int passes;

  tick_timer_scheduler #(
    .FREQ(100), .TICK_HZ(10), .CHANNELS(4), .CNT_W(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_cmd     (cfg_cmd),
    .cfg_load    (cfg_load),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_chan    (evt_chan),
    .evt_overrun (evt_overrun),
    .active      (active),
    .base_tick   (base_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_cmd   = '0;
    cfg_load  = '0;
    evt_ready = 1'b0;
    step;
    step;
    reset = 1'b0;
    step;
  endtask

  task automatic send_cmd(input logic [1:0] ch, input logic [1:0] cmd, input logic [7:0] load);
    cfg_valid = 1'b1;
    cfg_chan  = ch;
    cfg_cmd   = cmd;
    cfg_load  = load;
    step;
    cfg_valid = 1'b0;
  endtask

  // Leaves the bench inside a cycle where base_tick is high.
  task automatic align(input string tag);
    int n;
    n = 0;
    while (base_tick !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    checks++;
    if (base_tick !== 1'b1) $display("[TB] FAIL %s_align: base_tick got %b expected 1", tag, base_tick);
    else passes++;
  endtask

  task automatic wait_evt(input int max, output int n);
    n = 0;
    while (evt_valid !== 1'b1 && n < max) begin
      step;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) $display("[TB] FAIL rst_cfg_ready_held: got %b expected 0", cfg_ready);
    else passes++;
    do_reset;
    checks++;
    if (cfg_ready !== 1'b1) $display("[TB] FAIL rst_cfg_ready: got %b expected 1", cfg_ready);
    else passes++;
    checks++;
    if (evt_valid !== 1'b0 || active !== 4'b0000 || evt_overrun !== 1'b0)
      $display("[TB] FAIL rst_outputs: got valid=%b active=%b ovr=%b expected 0/0000/0", evt_valid, active, evt_overrun);
    else passes++;
    align("rst");
    step;
    checks++;
    if (base_tick !== 1'b0) $display("[TB] FAIL rst_tick_low: got %b expected 0", base_tick);
    else passes++;
    repeat (8) step;
    checks++;
    if (base_tick !== 1'b0) $display("[TB] FAIL rst_tick_cnt8: got %b expected 0", base_tick);
    else passes++;
    step;
    checks++;
    if (base_tick !== 1'b1) $display("[TB] FAIL rst_tick_period: got %b expected 1", base_tick);
    else passes++;
  endtask

  task automatic test_oneshot;
    int n;
    do_reset;
    align("os");
    step;
    send_cmd(2'd0, C_ONE, 8'd3);
    checks++;
    if (active !== 4'b0001) $display("[TB] FAIL os_active: got %b expected 0001", active);
    else passes++;
    wait_evt(60, n);
    checks++;
    if (n !== 30) $display("[TB] FAIL os_latency: got %0d expected 30", n);
    else passes++;
    checks++;
    if (evt_chan !== 2'd0 || evt_overrun !== 1'b0)
      $display("[TB] FAIL os_event: got chan=%0d ovr=%b expected 0/0", evt_chan, evt_overrun);
    else passes++;
    evt_ready = 1'b1;
    step;
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0 || active !== 4'b0000)
      $display("[TB] FAIL os_after: got valid=%b active=%b expected 0/0000", evt_valid, active);
    else passes++;
    wait_evt(40, n);
    checks++;
    if (n !== 40) $display("[TB] FAIL os_no_repeat: got %0d cycles expected 40", n);
    else passes++;
  endtask

  task automatic test_periodic;
    int n;
    do_reset;
    evt_ready = 1'b1;
    align("per");
    step;
    send_cmd(2'd1, C_PER, 8'd2);
    wait_evt(60, n);
    checks++;
    if (n !== 20 || evt_chan !== 2'd1)
      $display("[TB] FAIL per_first: got n=%0d chan=%0d expected 20/1", n, evt_chan);
    else passes++;
    step;
    checks++;
    if (evt_valid !== 1'b0) $display("[TB] FAIL per_pulse: got %b expected 0", evt_valid);
    else passes++;
    wait_evt(60, n);
    checks++;
    if (n !== 19 || evt_chan !== 2'd1)
      $display("[TB] FAIL per_second: got n=%0d chan=%0d expected 19/1", n, evt_chan);
    else passes++;
    step;
    send_cmd(2'd1, C_STOP, 8'd0);
    checks++;
    if (active !== 4'b0000) $display("[TB] FAIL per_stop_active: got %b expected 0000", active);
    else passes++;
    wait_evt(60, n);
    checks++;
    if (n !== 60) $display("[TB] FAIL per_stopped: got %0d cycles expected 60", n);
    else passes++;
    evt_ready = 1'b0;
  endtask

  task automatic test_overrun;
    do_reset;
    align("ovr");
    step;
    for (int c = 0; c < 4; c++) send_cmd(2'(c), C_PER, 8'd1);
    checks++;
    if (active !== 4'b1111) $display("[TB] FAIL ovr_active: got %b expected 1111", active);
    else passes++;
    repeat (25) step;
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_chan !== 2'(k) || evt_overrun !== 1'b1)
        $display("[TB] FAIL ovr_evt%0d: got valid=%b chan=%0d ovr=%b expected 1/%0d/1",
                 k, evt_valid, evt_chan, evt_overrun, k);
      else passes++;
      step;
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_load_zero_restart;
    int n;
    do_reset;
    align("lz");
    step;
    send_cmd(2'd2, C_ONE, 8'd0);
    wait_evt(40, n);
    checks++;
    if (n !== 10 || evt_chan !== 2'd2)
      $display("[TB] FAIL lz_event: got n=%0d chan=%0d expected 10/2", n, evt_chan);
    else passes++;
    evt_ready = 1'b1;
    step;
    evt_ready = 1'b0;
    checks++;
    if (active !== 4'b0000) $display("[TB] FAIL lz_idle: got %b expected 0000", active);
    else passes++;
    send_cmd(2'd2, C_ONE, 8'd1);
    checks++;
    if (active !== 4'b0100) $display("[TB] FAIL rs_active: got %b expected 0100", active);
    else passes++;
    align("rs");
    send_cmd(2'd2, C_ONE, 8'd5);
    wait_evt(80, n);
    checks++;
    if (n !== 51 || evt_chan !== 2'd2)
      $display("[TB] FAIL rs_restart: got n=%0d chan=%0d expected 51/2", n, evt_chan);
    else passes++;
    evt_ready = 1'b1;
    step;
    evt_ready = 1'b0;
  endtask

  task automatic test_clear;
    int n;
    do_reset;
    align("clr");
    step;
    send_cmd(2'd1, C_ONE, 8'd1);
    send_cmd(2'd3, C_ONE, 8'd1);
    wait_evt(40, n);
    checks++;
    if (n !== 9 || evt_chan !== 2'd1)
      $display("[TB] FAIL clr_first: got n=%0d chan=%0d expected 9/1", n, evt_chan);
    else passes++;
    send_cmd(2'd1, C_CLR, 8'd0);
    checks++;
    if (evt_valid !== 1'b0) $display("[TB] FAIL clr_drop: got %b expected 0", evt_valid);
    else passes++;
    step;
    checks++;
    if (evt_valid !== 1'b1 || evt_chan !== 2'd3 || evt_overrun !== 1'b0)
      $display("[TB] FAIL clr_next: got valid=%b chan=%0d ovr=%b expected 1/3/0", evt_valid, evt_chan, evt_overrun);
    else passes++;
    evt_ready = 1'b1;
    step;
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0) $display("[TB] FAIL clr_empty: got %b expected 0", evt_valid);
    else passes++;
  endtask

  task automatic test_async_reset;
    int n;
    do_reset;
    align("ar");
    step;
    send_cmd(2'd0, C_PER, 8'd1);
    send_cmd(2'd1, C_PER, 8'd3);
    wait_evt(40, n);
    checks++;
    if (evt_valid !== 1'b1) $display("[TB] FAIL ar_pre_valid: got %b expected 1", evt_valid);
    else passes++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || evt_chan !== 2'd0 || evt_overrun !== 1'b0 ||
        active !== 4'b0000 || base_tick !== 1'b0 || cfg_ready !== 1'b0)
      $display("[TB] FAIL ar_outputs: got valid=%b chan=%0d ovr=%b active=%b tick=%b rdy=%b expected all 0",
               evt_valid, evt_chan, evt_overrun, active, base_tick, cfg_ready);
    else passes++;
    step;
    step;
    reset = 1'b0;
    step;
    checks++;
    if (cfg_ready !== 1'b1) $display("[TB] FAIL ar_cfg_ready: got %b expected 1", cfg_ready);
    else passes++;
    wait_evt(60, n);
    checks++;
    if (n !== 60 || active !== 4'b0000)
      $display("[TB] FAIL ar_quiet: got n=%0d active=%b expected 60/0000", n, active);
    else passes++;
    send_cmd(2'd2, C_ONE, 8'd1);
    wait_evt(30, n);
    checks++;
    if (evt_valid !== 1'b1 || evt_chan !== 2'd2)
      $display("[TB] FAIL ar_restart: got valid=%b chan=%0d expected 1/2", evt_valid, evt_chan);
    else passes++;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_cmd   = '0;
    cfg_load  = '0;
    evt_ready = 1'b0;
    $display("[TB] tick_timer_scheduler directed tests");
    test_reset;
    test_oneshot;
    test_periodic;
    test_overrun;
    test_load_zero_restart;
    test_clear;
    test_async_reset;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
